line_follow_ctrl: RTL

Motion sequencer sitting between the three-sensor line tracker and the two motor PWM drivers. It debounces the tracker's 2-bit steering decision, runs a drive state machine (forward, turn, lost-line search, halt), and drives registered per-wheel speed and direction commands. It owns recovery when the line is lost and the decision to give up.

---
 rtl/line_follow_if.sv | 24 ++
 rtl/line_follow_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_follow_if.sv
// Handshake bundle between the line tracker/host and line_follow_ctrl.
// Carries the steering inputs and the registered wheel command outputs.
interface line_follow_if #(
    parameter int SPD_W = 10
);
    logic             enable;
    logic [1:0]       track_state;
    logic             obstacle;
    logic [SPD_W-1:0] left_speed;
    logic [SPD_W-1:0] right_speed;
    logic             left_dir;
    logic             right_dir;
    logic [2:0]       mode;

    modport master (
        output enable, track_state, obstacle,
        input  left_speed, right_speed, left_dir, right_dir, mode
    );

    modport slave (
        input  enable, track_state, obstacle,
        output left_speed, right_speed, left_dir, right_dir, mode
    );
endinterface

// File: rtl/line_follow_ctrl.sv
// Line-follow motion sequencer: debounces the tracker decision and drives wheel commands.
// Optional macro OBSTACLE_STOP_EN adds the BLOCKED state driven by the obstacle input.
module line_follow_ctrl #(
    parameter int DEBOUNCE       = 4,
    parameter int SEARCH_TIMEOUT = 5000,
    parameter int SPD_W          = 10,
    parameter int FWD_SPEED      = 700,
    parameter int TURN_FAST      = 700,
    parameter int TURN_SLOW      = 200,
    parameter int SEARCH_SPEED   = 400
) (
    input  logic          clk,
    input  logic          reset,
    line_follow_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FWD     = 3'd1,
        ST_TURN_L  = 3'd2,
        ST_TURN_R  = 3'd3,
        ST_SEARCH  = 3'd4,
        ST_HALT    = 3'd5,
        ST_BLOCKED = 3'd6
    } state_t;

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
    localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_TIMEOUT - 1);

    localparam logic [SPD_W-1:0] FWD_S    = SPD_W'(FWD_SPEED);
    localparam logic [SPD_W-1:0] FAST_S   = SPD_W'(TURN_FAST);
    localparam logic [SPD_W-1:0] SLOW_S   = SPD_W'(TURN_SLOW);
    localparam logic [SPD_W-1:0] SEARCH_S = SPD_W'(SEARCH_SPEED);
    localparam logic [SPD_W-1:0] ZERO_S   = {SPD_W{1'b0}};

    logic [1:0]       cand_r;
    logic [DW-1:0]    deb_cnt_r;
    logic [DW-1:0]    deb_cnt_nxt_s;
    logic             deb_accept_s;
    logic [1:0]       acc_r;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SW-1:0]    search_cnt_r;
    logic [SW-1:0]    search_cnt_nxt_s;
    logic             last_turn_r;      // 0 = left, 1 = right
    logic             last_turn_nxt_s;

    logic [SPD_W-1:0] left_speed_r;
    logic [SPD_W-1:0] right_speed_r;
    logic             left_dir_r;
    logic             right_dir_r;

    function automatic state_t follow_state(input logic [1:0] decision);
        state_t st;
        case (decision)
            2'b11:   st = ST_FWD;
            2'b10:   st = ST_TURN_L;
            2'b01:   st = ST_TURN_R;
            default: st = ST_SEARCH;
        endcase
        return st;
    endfunction

    // Debounce counter: counts repeat samples of the candidate, saturating once accepted.
    always_comb begin
        deb_cnt_nxt_s = {DW{1'b0}};
        if (bus.track_state == cand_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_cnt_nxt_s = deb_cnt_r;
            end else begin
                deb_cnt_nxt_s = deb_cnt_r + DW'(1);
            end
        end else begin
            deb_cnt_nxt_s = {DW{1'b0}};
        end
        deb_accept_s = (deb_cnt_nxt_s == DEB_LAST);
    end

    // Debounce registers: candidate, run length and accepted decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_r    <= 2'b00;
            deb_cnt_r <= {DW{1'b0}};
            acc_r     <= 2'b00;
        end else begin
            cand_r    <= bus.track_state;
            deb_cnt_r <= deb_cnt_nxt_s;
            if (deb_accept_s) begin
                acc_r <= bus.track_state;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Next-state, search counter and pivot-direction selection.
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.enable) begin
            state_nxt_s = ST_IDLE;
`ifdef OBSTACLE_STOP_EN
        end else if (bus.obstacle && (state_r == ST_FWD || state_r == ST_TURN_L ||
                                      state_r == ST_TURN_R || state_r == ST_SEARCH)) begin
            state_nxt_s = ST_BLOCKED;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_FWD, ST_TURN_L, ST_TURN_R: state_nxt_s = follow_state(acc_r);
                ST_SEARCH: begin
                    // Reacquiring the line takes precedence over the timeout.
                    if (acc_r != 2'b00) begin
                        state_nxt_s = follow_state(acc_r);
                    end else if (search_cnt_r == SEARCH_LAST) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_SEARCH;
                    end
                end
                ST_HALT: state_nxt_s = ST_HALT;
`ifdef OBSTACLE_STOP_EN
                ST_BLOCKED: begin
                    if (bus.obstacle) begin
                        state_nxt_s = ST_BLOCKED;
                    end else begin
                        state_nxt_s = follow_state(acc_r);
                    end
                end
`endif
                default: state_nxt_s = ST_IDLE;
            endcase
        end

        // Leaving BLOCKED back into SEARCH resumes the held count instead of restarting it.
        search_cnt_nxt_s = search_cnt_r;
        if (state_nxt_s == ST_SEARCH) begin
            if (state_r == ST_SEARCH) begin
                search_cnt_nxt_s = search_cnt_r + SW'(1);
            end else if (state_r == ST_BLOCKED) begin
                search_cnt_nxt_s = search_cnt_r;
            end else begin
                search_cnt_nxt_s = {SW{1'b0}};
            end
        end else begin
            search_cnt_nxt_s = search_cnt_r;
        end

        last_turn_nxt_s = last_turn_r;
        if (state_nxt_s == ST_TURN_L && state_r != ST_TURN_L) begin
            last_turn_nxt_s = 1'b0;
        end else if (state_nxt_s == ST_TURN_R && state_r != ST_TURN_R) begin
            last_turn_nxt_s = 1'b1;
        end else begin
            last_turn_nxt_s = last_turn_r;
        end
    end

    // Drive FSM with wheel commands registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            search_cnt_r  <= {SW{1'b0}};
            last_turn_r   <= 1'b0;
            left_speed_r  <= ZERO_S;
            right_speed_r <= ZERO_S;
            left_dir_r    <= 1'b1;
            right_dir_r   <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            search_cnt_r <= search_cnt_nxt_s;
            last_turn_r  <= last_turn_nxt_s;
            case (state_nxt_s)
                ST_FWD: begin
                    left_speed_r  <= FWD_S;
                    right_speed_r <= FWD_S;
                    left_dir_r    <= 1'b1;
                    right_dir_r   <= 1'b1;
                end
                ST_TURN_L: begin
                    left_speed_r  <= SLOW_S;
                    right_speed_r <= FAST_S;
                    left_dir_r    <= 1'b1;
                    right_dir_r   <= 1'b1;
                end
                ST_TURN_R: begin
                    left_speed_r  <= FAST_S;
                    right_speed_r <= SLOW_S;
                    left_dir_r    <= 1'b1;
                    right_dir_r   <= 1'b1;
                end
                ST_SEARCH: begin
                    left_speed_r  <= SEARCH_S;
                    right_speed_r <= SEARCH_S;
                    left_dir_r    <= last_turn_nxt_s;
                    right_dir_r   <= ~last_turn_nxt_s;
                end
                default: begin
                    left_speed_r  <= ZERO_S;
                    right_speed_r <= ZERO_S;
                    left_dir_r    <= 1'b1;
                    right_dir_r   <= 1'b1;
                end
            endcase
        end
    end

`ifndef OBSTACLE_STOP_EN
    logic obstacle_unused_s;
    assign obstacle_unused_s = bus.obstacle;
`endif

    assign bus.mode        = state_r;
    assign bus.left_speed  = left_speed_r;
    assign bus.right_speed = right_speed_r;
    assign bus.left_dir    = left_dir_r;
    assign bus.right_dir   = right_dir_r;

endmodule
